// File: rtl/vdp_pkg.sv
// Shared constants for the VDP colour output path: CRAM byte layout, palette
// base for backdrop/sprite entries, pipeline depth and the channel expander.
package vdp_pkg;

    localparam int         PIPE_LATENCY  = 3;
    localparam logic [4:0] BACKDROP_BASE = 5'd16;
    localparam int         CRAM_BYTES    = 64;

    // Game Gear: even byte {G,R}, odd byte {-,B}; 4 bits per channel.
    localparam int GG_CH_W   = 4;
    localparam int GG_R_LSB  = 0;
    localparam int GG_G_LSB  = 4;
    localparam int GG_B_LSB  = 0;

    // SMS: one byte per entry {-,-,B,G,R}; 2 bits per channel.
    localparam int SMS_CH_W  = 2;
    localparam int SMS_R_LSB = 0;
    localparam int SMS_G_LSB = 2;
    localparam int SMS_B_LSB = 4;

    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RESET = '{blank: 1'b1, hs: 1'b1, vs: 1'b1};

    // Output bit i (counted from the MSB) repeats source bit (i mod src_w),
    // so a narrow channel is replicated and a wide one keeps its MSBs.
    function automatic logic [7:0] expand_channel(input logic [7:0] src,
                                                  input int         src_w,
                                                  input int         cw);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < cw) begin
                res[3'(i)] = src[3'(src_w - 1 - ((cw - 1 - i) % src_w))];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vdp_cram.sv
// Palette storage: 64x8 with one write port and two synchronous read ports.
// A read of the byte being written in the same cycle returns the new data.
module vdp_cram
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr_a,
    input  logic [5:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b
);

    logic [7:0] mem_q [CRAM_BYTES];
    logic [7:0] rdata_a_d, rdata_a_q;
    logic [7:0] rdata_b_d, rdata_b_q;

    always_comb begin
        rdata_a_d = mem_q[raddr_a];
        rdata_b_d = mem_q[raddr_b];
        if (we && (waddr == raddr_a)) rdata_a_d = wdata;
        if (we && (waddr == raddr_b)) rdata_b_d = wdata;
    end

    // Storage and read registers are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/vdp_color_out.sv
// VDP colour output: palette index select, CRAM lookup and channel expansion
// in a fixed three-stage pipeline, with syncs delayed to match.
module vdp_color_out
    import vdp_pkg::*;
#(
    parameter int GG_MODE = 1,
    parameter int CW      = 4,
    parameter int WIN_X0  = 0,
    parameter int WIN_Y0  = 0,
    parameter int WIN_W   = 256,
    parameter int WIN_H   = 192
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          de,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic [4:0]    bg_color,
    input  logic          bg_priority,
    input  logic [3:0]    spr_color,
    input  logic [3:0]    backdrop_idx,
    input  logic          mask_left8,
    input  logic          cram_we,
    input  logic [5:0]    cram_addr,
    input  logic [7:0]    cram_wdata,
    output logic [CW-1:0] vga_r,
    output logic [CW-1:0] vga_g,
    output logic [CW-1:0] vga_b,
    output logic          hs_out,
    output logic          vs_out,
    output logic          de_out
);

    localparam int SRC_W = (GG_MODE != 0) ? GG_CH_W : SMS_CH_W;

    logic [4:0]    idx_d, idx_q;
    pipe_ctl_t     ctl_d [PIPE_LATENCY];
    pipe_ctl_t     ctl_q [PIPE_LATENCY];
    int            xi, yi;
    logic          in_win, in_mask;
    logic [5:0]    cram_waddr, raddr_a, raddr_b;
    logic [7:0]    byte_a, byte_b;
    logic [7:0]    src_r, src_g, src_b;
    logic [CW-1:0] vga_r_d, vga_r_q, vga_g_d, vga_g_q, vga_b_d, vga_b_q;
    logic          unused_cram_bits;

    // Stage 1: palette index selection.
    always_comb begin
        xi      = int'(x);
        yi      = int'(y);
        in_win  = (xi >= WIN_X0) && (xi < WIN_X0 + WIN_W) &&
                  (yi >= WIN_Y0) && (yi < WIN_Y0 + WIN_H);
        in_mask = mask_left8 && ((xi - WIN_X0) < 8);
        idx_d   = bg_color;
        if (!in_win || in_mask) begin
            idx_d = BACKDROP_BASE + {1'b0, backdrop_idx};
        end else if ((spr_color != 4'd0) &&
                     !(bg_priority && (bg_color[3:0] != 4'd0))) begin
            idx_d = BACKDROP_BASE + {1'b0, spr_color};
        end
    end

    always_comb begin
        ctl_d[0] = '{blank: ~de, hs: hs_in, vs: vs_in};
        for (int i = 1; i < PIPE_LATENCY; i++) begin
            ctl_d[i] = ctl_q[i-1];
        end
    end

    // Stage 2: CRAM lookup. SMS has 32 bytes, so the top address bit is dropped.
    always_comb begin
        cram_waddr = (GG_MODE != 0) ? cram_addr : {1'b0, cram_addr[4:0]};
        raddr_a    = (GG_MODE != 0) ? {idx_q, 1'b0} : {1'b0, idx_q};
        raddr_b    = {idx_q, 1'b1};
    end

    vdp_cram u_cram (
        .clk     (clk),
        .we      (cram_we),
        .waddr   (cram_waddr),
        .wdata   (cram_wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (byte_a),
        .rdata_b (byte_b)
    );

    assign unused_cram_bits = ^byte_b[7:4];

    // Stage 3: field extraction and expansion; blank overrides the palette.
    always_comb begin
        if (GG_MODE != 0) begin
            src_r = 8'(byte_a[GG_R_LSB +: GG_CH_W]);
            src_g = 8'(byte_a[GG_G_LSB +: GG_CH_W]);
            src_b = 8'(byte_b[GG_B_LSB +: GG_CH_W]);
        end else begin
            src_r = 8'(byte_a[SMS_R_LSB +: SMS_CH_W]);
            src_g = 8'(byte_a[SMS_G_LSB +: SMS_CH_W]);
            src_b = 8'(byte_a[SMS_B_LSB +: SMS_CH_W]);
        end
        vga_r_d = CW'(expand_channel(src_r, SRC_W, CW));
        vga_g_d = CW'(expand_channel(src_g, SRC_W, CW));
        vga_b_d = CW'(expand_channel(src_b, SRC_W, CW));
        if (ctl_q[PIPE_LATENCY-2].blank) begin
            vga_r_d = '0;
            vga_g_d = '0;
            vga_b_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                ctl_q[i] <= CTL_RESET;
            end
            vga_r_q <= '0;
            vga_g_q <= '0;
            vga_b_q <= '0;
        end else begin
            idx_q <= idx_d;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                ctl_q[i] <= ctl_d[i];
            end
            vga_r_q <= vga_r_d;
            vga_g_q <= vga_g_d;
            vga_b_q <= vga_b_d;
        end
    end

    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign hs_out = ctl_q[PIPE_LATENCY-1].hs;
    assign vs_out = ctl_q[PIPE_LATENCY-1].vs;
    assign de_out = ~ctl_q[PIPE_LATENCY-1].blank;

endmodule

// File: tb/tb_vdp_color_out.sv
// Bench for vdp_color_out: a Game Gear and an SMS instance share stimulus;
// expected {r,g,b,hs,vs,de} words queue up and are checked three clocks later.
module tb_vdp_color_out;

    localparam int W = 16;  // {check, r[3:0], g[3:0], b[3:0], hs, vs, de}
    localparam logic [W-1:0] RST_WORD = {1'b1, 12'h000, 3'b110};

    logic       clk;
    logic       rst_n;
    logic [9:0] x, y;
    logic       de, hs_in, vs_in;
    logic [4:0] bg_color;
    logic       bg_priority;
    logic [3:0] spr_color, backdrop_idx;
    logic       mask_left8;
    logic       cram_we;
    logic [5:0] cram_addr;
    logic [7:0] cram_wdata;

    logic [3:0] gg_r, gg_g, gg_b, sms_r, sms_g, sms_b;
    logic       gg_hs, gg_vs, gg_de, sms_hs, sms_vs, sms_de;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_sms_q[$];
    string        tag_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    vdp_color_out #(.GG_MODE(1), .CW(4)) dut_gg (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de), .hs_in(hs_in), .vs_in(vs_in),
        .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
        .backdrop_idx(backdrop_idx), .mask_left8(mask_left8), .cram_we(cram_we),
        .cram_addr(cram_addr), .cram_wdata(cram_wdata),
        .vga_r(gg_r), .vga_g(gg_g), .vga_b(gg_b),
        .hs_out(gg_hs), .vs_out(gg_vs), .de_out(gg_de)
    );

    vdp_color_out #(.GG_MODE(0), .CW(4)) dut_sms (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de), .hs_in(hs_in), .vs_in(vs_in),
        .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
        .backdrop_idx(backdrop_idx), .mask_left8(mask_left8), .cram_we(cram_we),
        .cram_addr(cram_addr), .cram_wdata(cram_wdata),
        .vga_r(sms_r), .vga_g(sms_g), .vga_b(sms_b),
        .hs_out(sms_hs), .vs_out(sms_vs), .de_out(sms_de)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed rgb/hs/vs/de=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [W-1:0] e);
        check({tag, "/gg"},  {gg_r, gg_g, gg_b, gg_hs, gg_vs, gg_de}, e[14:0]);
        check({tag, "/sms"}, {sms_r, sms_g, sms_b, sms_hs, sms_vs, sms_de}, e[14:0]);
    endtask

    // The pipeline state right after reset release: two blank stages in flight.
    task automatic restart_model();
        exp_q.delete();
        exp_sms_q.delete();
        tag_q.delete();
        repeat (2) begin
            exp_q.push_back(RST_WORD);
            exp_sms_q.push_back(RST_WORD);
            tag_q.push_back("post_reset_blank");
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input string tag, input logic [W-1:0] e_gg, input logic [W-1:0] e_sms);
        exp_q.push_back(e_gg);
        exp_sms_q.push_back(e_sms);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        while (exp_q.size() >= 3) begin
            logic [W-1:0] eg, es;
            string        t;
            eg = exp_q.pop_front();
            es = exp_sms_q.pop_front();
            t  = tag_q.pop_front();
            if (eg[W-1]) check({t, "/gg"}, {gg_r, gg_g, gg_b, gg_hs, gg_vs, gg_de}, eg[14:0]);
            if (es[W-1]) check({t, "/sms"}, {sms_r, sms_g, sms_b, sms_hs, sms_vs, sms_de}, es[14:0]);
        end
    endtask

    task automatic pix(input string tag, input int px_x, input int px_y, input logic [4:0] bg,
                       input logic prio, input logic [3:0] spr,
                       input logic [11:0] rgb_gg, input logic [11:0] rgb_sms);
        x = 10'(px_x);
        y = 10'(px_y);
        de = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        bg_color = bg;
        bg_priority = prio;
        spr_color = spr;
        step(tag, {1'b1, rgb_gg, 3'b111}, {1'b1, rgb_sms, 3'b111});
    endtask

    task automatic blank_px(input string tag, input logic h, input logic v);
        de = 1'b0;
        hs_in = h;
        vs_in = v;
        step(tag, {1'b1, 12'h000, h, v, 1'b0}, {1'b1, 12'h000, h, v, 1'b0});
    endtask

    task automatic wr_byte(input logic [5:0] a, input logic [7:0] d);
        cram_we = 1'b1;
        cram_addr = a;
        cram_wdata = d;
        @(posedge clk);
        #1;
        cram_we = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        x = '0; y = '0; de = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        bg_color = '0; bg_priority = 1'b0; spr_color = '0;
        backdrop_idx = 4'd4; mask_left8 = 1'b0;
        cram_we = 1'b0; cram_addr = '0; cram_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_both("reset_state", RST_WORD);

        // CRAM loaded while held in reset; SMS aliases addr[5] away.
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) wr_byte(6'(i), 8'h00);
        wr_byte(6'd2,  8'h5A); wr_byte(6'd3,  8'h03);
        wr_byte(6'd4,  8'h21); wr_byte(6'd5,  8'h07);
        wr_byte(6'd38, 8'hC3); wr_byte(6'd39, 8'h0E);
        wr_byte(6'd40, 8'h96); wr_byte(6'd41, 8'h08);
        wr_byte(6'd17, 8'h39);
        wr_byte(6'd51, 8'h24); wr_byte(6'd52, 8'h3F);
        check_both("reset_hold", RST_WORD);

        rst_n = 1'b1;
        restart_model();

        pix("bg_entry1",      10,  10, 5'd1, 1'b0, 4'd0, 12'hA53, 12'h000);
        pix("spr_entry17",    20,  10, 5'd1, 1'b0, 4'd1, 12'h000, 12'h5AF);
        pix("prio_bg2",       30,  10, 5'd2, 1'b1, 4'd3, 12'h127, 12'hAA5);
        pix("prio_bg0_spr",   31,  10, 5'd0, 1'b1, 4'd3, 12'h3CE, 12'h05A);
        pix("spr_over_bg2",   32,  10, 5'd2, 1'b0, 4'd3, 12'h3CE, 12'h05A);
        pix("x255_inside",   255,  10, 5'd1, 1'b0, 4'd0, 12'hA53, 12'h000);
        pix("x256_backdrop", 256,  10, 5'd1, 1'b0, 4'd0, 12'h698, 12'hFFF);
        pix("y191_inside",   100, 191, 5'd1, 1'b0, 4'd0, 12'hA53, 12'h000);
        pix("y192_backdrop", 100, 192, 5'd1, 1'b0, 4'd0, 12'h698, 12'hFFF);
        mask_left8 = 1'b1;
        pix("mask_x0",         0,  10, 5'd1, 1'b0, 4'd0, 12'h698, 12'hFFF);
        pix("mask_x7",         7,  10, 5'd1, 1'b0, 4'd0, 12'h698, 12'hFFF);
        pix("mask_x8",         8,  10, 5'd1, 1'b0, 4'd0, 12'hA53, 12'h000);
        mask_left8 = 1'b0;
        pix("nomask_x0",       0,  10, 5'd1, 1'b0, 4'd0, 12'hA53, 12'h000);

        // Blank inside the window with a non-zero entry selected.
        blank_px("blank_hs0",   1'b0, 1'b1);
        blank_px("blank_vs0",   1'b1, 0);
        blank_px("blank_both",  1'b0, 1'b0);
        blank_px("blank_idle",  1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            blank_px("rand_sync", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            pix("rand_window", int'($urandom_range(8, 255)), int'($urandom_range(0, 191)),
                5'd1, 1'b0, 4'd0, 12'hA53, 12'h000);
        end

        // Entry 1 is read on the same edge that byte 2 is rewritten.
        pix("write_first_read", 50, 10, 5'd1, 1'b0, 4'd0, 12'h0F3, 12'h000);
        cram_we = 1'b1; cram_addr = 6'd2; cram_wdata = 8'hF0;
        pix("write_first_next", 51, 10, 5'd1, 1'b0, 4'd0, 12'h0F3, 12'h000);
        cram_we = 1'b0;
        pix("sms_byte2_new",    52, 10, 5'd2, 1'b0, 4'd0, 12'h127, 12'h00F);
        pix("pre_reset_a",      53, 10, 5'd2, 1'b0, 4'd0, 12'h127, 12'h00F);
        pix("pre_reset_b",      54, 10, 5'd1, 1'b0, 4'd0, 12'h0F3, 12'h000);

        // Mid-line reset: outputs drop at once, CRAM keeps its contents.
        rst_n = 1'b0;
        #1 check_both("midline_reset", RST_WORD);
        @(posedge clk);
        #1 check_both("midline_reset_hold", RST_WORD);
        rst_n = 1'b1;
        restart_model();
        pix("after_reset_entry1", 10, 10, 5'd1, 1'b0, 4'd0, 12'h0F3, 12'h000);
        pix("after_reset_entry2", 11, 10, 5'd2, 1'b0, 4'd0, 12'h127, 12'h00F);
        pix("after_reset_spr",    12, 10, 5'd1, 1'b0, 4'd1, 12'h000, 12'h5AF);
        blank_px("flush_0", 1'b1, 1'b1);
        blank_px("flush_1", 1'b1, 1'b1);
        blank_px("flush_2", 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vdp_color_out.md
VDP_COLOR_OUT -- requirements
Module: vdp_color_out

Interface
REQ-001 Parameter GG_MODE, default 1: 1 = Game Gear CRAM (64 bytes, entry n = byte 2n {G[3:0],R[3:0]}, byte 2n+1 {4'bx,B[3:0]}); 0 = SMS CRAM (32 bytes, entry n = byte n {2'bx,B[1:0],G[1:0],R[1:0]}).
REQ-002 Parameter CW, default 4: output bits per channel, legal 1..8.
REQ-003 Parameters WIN_X0/WIN_Y0, default 0/0; WIN_W/WIN_H, default 256/192: active VDP window in VGA pixel coordinates.
REQ-004 clk  input  1  pixel clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 x, y  input  10 each  current VGA pixel coordinate.
REQ-007 de, hs_in, vs_in  input  1 each  display-enable and syncs aligned with x/y.
REQ-008 bg_color  input  5  background palette index; bit 4 selects the upper half.
REQ-009 bg_priority  input  1  background tile drawn over sprites.
REQ-010 spr_color  input  4  sprite index into the upper palette; 0 = transparent.
REQ-011 backdrop_idx  input  4  overscan colour, upper palette entry 16+backdrop_idx.
REQ-012 mask_left8  input  1  replace the first 8 window columns with backdrop.
REQ-013 cram_we  input  1; cram_addr  input  6; cram_wdata  input  8  byte write port; in SMS mode cram_addr[5] is ignored.
REQ-014 vga_r, vga_g, vga_b  output  CW each  registered colour.
REQ-015 hs_out, vs_out, de_out  output  1 each  syncs and enable delayed to match colour.

Function
REQ-016 Fixed latency of 3 clocks from x/y/de/colour inputs to vga_*; hs/vs/de take the identical delay.
REQ-017 Stage 1 computes a 5-bit index: de=0 -> blank flag; outside window -> 16+backdrop_idx; mask_left8 and (x-WIN_X0)<8 -> 16+backdrop_idx; spr_color!=0 and not (bg_priority and bg_color[3:0]!=0) -> 16+spr_color; otherwise bg_color.
REQ-018 Window test: WIN_X0<=x<WIN_X0+WIN_W and WIN_Y0<=y<WIN_Y0+WIN_H; exact boundary pixels x=WIN_X0+WIN_W-1 are inside, x=WIN_X0+WIN_W outside.
REQ-019 Stage 2 is a synchronous CRAM read of the entry's byte(s).
REQ-020 A CRAM write hitting a byte read in the same cycle SHALL return the new data (write-first).
REQ-021 Stage 3 expands each channel to CW bits by MSB-first bit replication (e.g. 2-bit 10 -> 1010 at CW=4); when source is wider than CW, keep the MSBs.
REQ-022 Blank flag forces vga_r/g/b to 0 irrespective of CRAM.
REQ-023 CRAM writes take effect on the clock edge; they are accepted during display and blanking alike.
REQ-024 Pipeline stalls never occur; every clock advances all stages.

Reset
REQ-025 While rst_n=0: vga_r/g/b=0, hs_out=1, vs_out=1, de_out=0, all pipeline valid/blank flags = blanking.
REQ-026 CRAM contents are not reset; simulation initialises them to 0.
REQ-027 Reset assertion mid-line takes effect immediately; the first 3 clocks after release output blank.

Structure
REQ-028 A shared package vdp_pkg holds CRAM byte-layout field positions, the backdrop base 16, and the pipeline latency constant 3.
REQ-029 One sub-module, vdp_cram (dual-port 64x8, write-first), holds palette storage; expansion and selection stay in vdp_color_out.

Verification
REQ-030 GG_MODE=1, CW=4: write bytes 2=0x5A, 3=0x03; bg_color=1 in window, spr 0 -> three clocks later r=A, g=5, b=3.
REQ-031 GG_MODE=0, CW=4: write byte 17=0x39 (B=11,G=10,R=01), spr_color=1, bg_priority=0 -> r=0x5, g=0xA, b=0xF.
REQ-032 bg_priority=1, bg_color=0x02, spr_color=3 -> background entry 2 shown; bg_color=0x00 same case -> entry 19 shown.
REQ-033 x=255 vs 256 with window 0..255, backdrop_idx=4 -> pixel 255 shows bg, pixel 256 shows entry 20; mask_left8=1, x=7 -> entry 20, x=8 -> bg.
REQ-034 Write byte 2 to 0xF0 in the same cycle entry 1 is read -> output g=F, r=0; de=0 -> rgb=0 with hs/vs delayed exactly 3 clocks.
REQ-035 Assert rst_n=0 mid-line -> outputs immediately at reset values; after release first 3 outputs blank, CRAM content preserved.
